// File: rtl/rv_decode_pkg.sv
// Shared RISC-V decode definitions: base opcodes and the immediate-format encoding.
package rv_decode_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_t;

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational opcode classifier and immediate generator, sign-extended to XLEN.
module rv_imm_gen
   import rv_decode_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output fmt_t            fmt,
   output logic            illegal,
   output logic            uses_rs1,
   output logic            uses_rs2
);

   logic [31:0] imm32;

   always_comb begin
      fmt     = FMT_R;
      illegal = 1'b0;
      imm32   = '0;
      case (instr[6:0])
         OP_REG, OP_REG32: fmt = FMT_R;
         OP_IMM, OP_IMM32, OP_LOAD, OP_JALR, OP_SYSTEM: begin
            fmt   = FMT_I;
            imm32 = {{20{instr[31]}}, instr[31:20]};
         end
         OP_STORE: begin
            fmt   = FMT_S;
            imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         OP_BRANCH: begin
            fmt   = FMT_B;
            imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            fmt   = FMT_U;
            imm32 = {instr[31:12], 12'b0};
         end
         OP_JAL: begin
            fmt   = FMT_J;
            imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         default: illegal = 1'b1;
      endcase
   end

   // Every 32-bit form already carries bit 31 in its MSB, so a signed widen finishes the job.
   assign imm      = XLEN'($signed(imm32));
   assign uses_rs1 = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
   assign uses_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);

endmodule

// File: rtl/stage_id_pipe.sv
// Registered instruction-decode stage: field extraction, immediates, RF read with
// write-back bypass, and load-use stall, with valid/ready on both sides.
module stage_id_pipe
   import rv_decode_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned RA_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   output logic [RA_W-1:0] rf_rs1,
   output logic [RA_W-1:0] rf_rs2,
   input  logic [XLEN-1:0] rf_data1,
   input  logic [XLEN-1:0] rf_data2,
   input  logic            wb_we,
   input  logic [RA_W-1:0] wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            ex_mem_read,
   input  logic [RA_W-1:0] ex_rd,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [RA_W-1:0] out_rs1,
   output logic [RA_W-1:0] out_rs2,
   output logic [RA_W-1:0] out_rd,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [6:0]      out_opcode,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic            out_illegal
);

   logic [XLEN-1:0] imm;
   fmt_t            fmt;
   logic            illegal;
   logic            uses_rs1;
   logic            uses_rs2;
   logic [RA_W-1:0] rs1;
   logic [RA_W-1:0] rs2;
   logic [RA_W-1:0] rd;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            hazard;
   logic            accept;

   rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr    (in_instr),
      .imm      (imm),
      .fmt      (fmt),
      .illegal  (illegal),
      .uses_rs1 (uses_rs1),
      .uses_rs2 (uses_rs2)
   );

   assign rs1    = RA_W'(in_instr[19:15]);
   assign rs2    = RA_W'(in_instr[24:20]);
   assign rd     = RA_W'(in_instr[11:7]);
   assign rf_rs1 = rs1;
   assign rf_rs2 = rs2;

   // x0 reads as zero; a same-cycle write-back to a live register overrides the RF.
   always_comb begin
      rs1_data = rf_data1;
      rs2_data = rf_data2;
      if (rs1 == '0)
         rs1_data = '0;
      else if (wb_we && (wb_rd == rs1))
         rs1_data = wb_data;
      if (rs2 == '0)
         rs2_data = '0;
      else if (wb_we && (wb_rd == rs2))
         rs2_data = wb_data;
   end

   assign hazard   = in_valid && ex_mem_read && (ex_rd != '0) &&
                     ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));
   assign in_ready = rst_n && (flush || ((!out_valid || out_ready) && !hazard));
   assign accept   = in_valid && in_ready && !flush;

   // Flush beats accept; a stalled bundle (out_valid & !out_ready) simply holds.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_pc       <= '0;
         out_rs1      <= '0;
         out_rs2      <= '0;
         out_rd       <= '0;
         out_funct3   <= '0;
         out_funct7   <= '0;
         out_opcode   <= '0;
         out_imm      <= '0;
         out_fmt      <= '0;
         out_rs1_data <= '0;
         out_rs2_data <= '0;
         out_illegal  <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid    <= 1'b1;
         out_pc       <= in_pc;
         out_rs1      <= rs1;
         out_rs2      <= rs2;
         out_rd       <= rd;
         out_funct3   <= in_instr[14:12];
         out_funct7   <= in_instr[31:25];
         out_opcode   <= in_instr[6:0];
         out_imm      <= imm;
         out_fmt      <= 3'(fmt);
         out_rs1_data <= rs1_data;
         out_rs2_data <= rs2_data;
         out_illegal  <= illegal;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stage_id_pipe.sv
// Directed bench for stage_id_pipe: decode vector table plus stall, hazard, bypass,
// flush and reset sequences; a second XLEN=64 instance checks wide sign extension.
module tb_stage_id_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic [4:0]  rf_rs1, rf_rs2;
   logic [31:0] rf_data1, rf_data2;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        ex_mem_read;
   logic [4:0]  ex_rd;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic [2:0]  out_funct3;
   logic [6:0]  out_funct7, out_opcode;
   logic [31:0] out_imm;
   logic [2:0]  out_fmt;
   logic [31:0] out_rs1_data, out_rs2_data;
   logic        out_illegal;

   logic [63:0] pc64, rf_data1_64, rf_data2_64, wb_data64;
   logic        in_ready64, out_valid64, out_illegal64;
   logic [4:0]  rf_rs1_64, rf_rs2_64, out_rs1_64, out_rs2_64, out_rd64;
   logic [2:0]  out_funct3_64, out_fmt64;
   logic [6:0]  out_funct7_64, out_opcode64;
   logic [63:0] out_pc64, out_imm64, out_rs1_data64, out_rs2_data64;

   assign pc64        = {32'h0, in_pc};
   assign rf_data1_64 = {32'h0, rf_data1};
   assign rf_data2_64 = {32'h0, rf_data2};
   assign wb_data64   = {32'h0, wb_data};

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   stage_id_pipe #(.XLEN(32), .RA_W(5)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_data1(rf_data1), .rf_data2(rf_data2),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
      .out_funct3(out_funct3), .out_funct7(out_funct7), .out_opcode(out_opcode),
      .out_imm(out_imm), .out_fmt(out_fmt),
      .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
      .out_illegal(out_illegal)
   );

   stage_id_pipe #(.XLEN(64), .RA_W(5)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
      .in_instr(in_instr), .in_pc(pc64), .flush(flush),
      .rf_rs1(rf_rs1_64), .rf_rs2(rf_rs2_64), .rf_data1(rf_data1_64), .rf_data2(rf_data2_64),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data64),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64),
      .out_rs1(out_rs1_64), .out_rs2(out_rs2_64), .out_rd(out_rd64),
      .out_funct3(out_funct3_64), .out_funct7(out_funct7_64), .out_opcode(out_opcode64),
      .out_imm(out_imm64), .out_fmt(out_fmt64),
      .out_rs1_data(out_rs1_data64), .out_rs2_data(out_rs2_data64),
      .out_illegal(out_illegal64)
   );

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [2:0]  fmt;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic        ill;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
   endtask

   localparam logic [31:0] I_ADDI = 32'hFFB10093;  // addi x1,x2,-5
   localparam logic [31:0] I_LUI  = 32'h123451B7;  // lui x3,0x12345
   localparam logic [31:0] I_ADD  = 32'h006283B3;  // add x7,x5,x6
   localparam logic [31:0] I_ADX0 = 32'h00100093;  // addi x1,x0,1

   initial begin
      vecs[0] = '{I_ADDI,       32'h1000, 3'd1, 32'hFFFFFFFB, 5'd1,  5'd2,  5'd27, 3'd0, 1'b0};
      vecs[1] = '{32'h00532423, 32'h1004, 3'd2, 32'h00000008, 5'd8,  5'd6,  5'd5,  3'd2, 1'b0};
      vecs[2] = '{32'hFE208EE3, 32'h1008, 3'd3, 32'hFFFFFFFC, 5'd29, 5'd1,  5'd2,  3'd0, 1'b0};
      vecs[3] = '{I_LUI,        32'h100C, 3'd4, 32'h12345000, 5'd3,  5'd8,  5'd3,  3'd5, 1'b0};
      vecs[4] = '{32'hFF9FF06F, 32'h1010, 3'd5, 32'hFFFFFFF8, 5'd0,  5'd31, 5'd25, 3'd7, 1'b0};
      vecs[5] = '{32'h0000007F, 32'h1014, 3'd0, 32'h00000000, 5'd0,  5'd0,  5'd0,  3'd0, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
      rf_data1 = '0; rf_data2 = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
      ex_mem_read = 1'b0; ex_rd = '0; out_ready = 1'b1;

      // Reset state
      step();
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_imm", 64'(out_imm), 64'd0);
      check("rst_out_pc", 64'(out_pc), 64'd0);
      rst_n = 1'b1;

      // Back-to-back decode table at full throughput
      for (int i = 0; i < 6; i++) begin
         drive(vecs[i].instr, vecs[i].pc);
         rf_data1 = 32'h11111111;
         rf_data2 = 32'h22222222;
         #1;
         check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
         check($sformatf("v%0d_rf_rs1", i), 64'(rf_rs1), 64'(vecs[i].rs1));
         step();
         check($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
         check($sformatf("v%0d_pc", i), 64'(out_pc), 64'(vecs[i].pc));
         check($sformatf("v%0d_fmt", i), 64'(out_fmt), 64'(vecs[i].fmt));
         check($sformatf("v%0d_imm", i), 64'(out_imm), 64'(vecs[i].imm));
         check($sformatf("v%0d_rd", i), 64'(out_rd), 64'(vecs[i].rd));
         check($sformatf("v%0d_rs1", i), 64'(out_rs1), 64'(vecs[i].rs1));
         check($sformatf("v%0d_rs2", i), 64'(out_rs2), 64'(vecs[i].rs2));
         check($sformatf("v%0d_funct3", i), 64'(out_funct3), 64'(vecs[i].f3));
         check($sformatf("v%0d_opcode", i), 64'(out_opcode), 64'(vecs[i].instr[6:0]));
         check($sformatf("v%0d_illegal", i), 64'(out_illegal), 64'(vecs[i].ill));
         check($sformatf("v%0d_rs1_data", i), 64'(out_rs1_data),
               (vecs[i].rs1 == 5'd0) ? 64'd0 : 64'h11111111);
         check($sformatf("v%0d_valid64", i), 64'(out_valid64), 64'd1);
         check($sformatf("v%0d_imm64", i), out_imm64, 64'($signed(vecs[i].imm)));
      end
      in_valid = 1'b0;
      step();
      check("drain_valid", 64'(out_valid), 64'd0);

      // Downstream stall for three cycles holds the bundle
      drive(I_ADDI, 32'h100);
      step();
      check("stall_load_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b0;
      drive(I_LUI, 32'h104);
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'd0);
         step();
         check($sformatf("stall%0d_valid", c), 64'(out_valid), 64'd1);
         check($sformatf("stall%0d_pc", c), 64'(out_pc), 64'h100);
         check($sformatf("stall%0d_imm", c), 64'(out_imm), 64'hFFFFFFFB);
      end
      out_ready = 1'b1;
      #1;
      check("unstall_in_ready", 64'(in_ready), 64'd1);
      step();
      check("unstall_pc", 64'(out_pc), 64'h104);
      check("unstall_imm", 64'(out_imm), 64'h12345000);
      in_valid = 1'b0;
      step();

      // Load-use hazard on rs1 inserts one bubble
      ex_mem_read = 1'b1; ex_rd = 5'd5;
      drive(I_ADD, 32'h300);
      #1;
      check("haz_in_ready", 64'(in_ready), 64'd0);
      step();
      check("haz_bubble", 64'(out_valid), 64'd0);
      ex_mem_read = 1'b0;
      #1;
      check("haz_release_ready", 64'(in_ready), 64'd1);
      step();
      check("haz_accept_valid", 64'(out_valid), 64'd1);
      check("haz_accept_pc", 64'(out_pc), 64'h300);
      check("haz_accept_rd", 64'(out_rd), 64'd7);
      check("haz_accept_fmt", 64'(out_fmt), 64'd0);
      ex_mem_read = 1'b1; ex_rd = 5'd0;
      drive(I_ADD, 32'h304);
      #1;
      check("haz_x0_ready", 64'(in_ready), 64'd1);
      step();
      check("haz_x0_pc", 64'(out_pc), 64'h304);
      ex_mem_read = 1'b0;

      // Write-back bypass, and x0 always reads zero
      wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEADBEEF;
      rf_data1 = 32'h0; rf_data2 = 32'h22;
      drive(I_ADDI, 32'h400);
      step();
      check("byp_rs1_data", 64'(out_rs1_data), 64'hDEADBEEF);
      check("byp_rs2_data", 64'(out_rs2_data), 64'h22);
      wb_rd = 5'd0; wb_data = 32'h99; rf_data1 = 32'h55; rf_data2 = 32'h77;
      drive(I_ADX0, 32'h404);
      step();
      check("x0_rs1_data", 64'(out_rs1_data), 64'd0);
      check("x0_rs2_data", 64'(out_rs2_data), 64'h77);
      wb_we = 1'b0;

      // Flush while stalled with an incoming instruction
      drive(I_ADDI, 32'h200);
      step();
      out_ready = 1'b0;
      flush = 1'b1;
      drive(I_LUI, 32'h204);
      #1;
      check("flush_in_ready", 64'(in_ready), 64'd1);
      step();
      check("flush_valid", 64'(out_valid), 64'd0);
      flush = 1'b0;
      step();
      check("postflush_pc", 64'(out_pc), 64'h204);
      check("postflush_valid", 64'(out_valid), 64'd1);

      // Flush wins over a simultaneous hazard
      out_ready = 1'b1; flush = 1'b1;
      ex_mem_read = 1'b1; ex_rd = 5'd6;
      drive(I_ADD, 32'h308);
      #1;
      check("flush_haz_ready", 64'(in_ready), 64'd1);
      step();
      check("flush_haz_valid", 64'(out_valid), 64'd0);
      flush = 1'b0; ex_mem_read = 1'b0;
      step();
      check("after_flush_pc", 64'(out_pc), 64'h308);

      // Reset mid-stream clears every registered output
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 64'(in_ready), 64'd0);
      step();
      check("midrst_valid", 64'(out_valid), 64'd0);
      check("midrst_pc", 64'(out_pc), 64'd0);
      check("midrst_rd", 64'(out_rd), 64'd0);
      check("midrst_rs1_data", 64'(out_rs1_data), 64'd0);
      check("midrst_imm64", out_imm64, 64'd0);
      rst_n = 1'b1; in_valid = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/stage_id_pipe.md
Name: stage_id_pipe

Overview:
Registered RV32/RV64 instruction-decode stage with valid/ready handshakes on both sides. It replaces the purely combinational decode.
- Extracts register fields and generates all five immediate formats (I/S/B/U/J), sign-extended to XLEN.
- Reads the register file, with write-back bypass.
- Detects load-use hazards and inserts bubbles.
- Sits between fetch (upstream) and execute (downstream), with one cycle of latency.

Parameters:
- XLEN, 32, datapath and immediate width; legal values 32 or 64.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction PC
- flush  in  1  kill the in-flight and incoming instruction (branch taken / trap)
- rf_rs1, rf_rs2  out  RA_W  combinational register-file read addresses, equal to in_instr[19:15] and in_instr[24:20]
- rf_data1, rf_data2  in  XLEN  combinational register-file read data
- wb_we, wb_rd, wb_data  in  1/RA_W/XLEN  write-back port, used for bypass
- ex_mem_read, ex_rd  in  1/RA_W  load currently in execute
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts the bundle
- out_pc  out  XLEN  PC of the decoded instruction
- out_rs1, out_rs2, out_rd  out  RA_W  register fields
- out_funct3  out  3  funct3 field
- out_funct7  out  7  funct7 field
- out_opcode  out  7  opcode field
- out_imm  out  XLEN  sign-extended immediate
- out_fmt  out  3  R=0, I=1, S=2, B=3, U=4, J=5
- out_rs1_data, out_rs2_data  out  XLEN  operand values after bypass
- out_illegal  out  1  unrecognised opcode

Behaviour:
- Reset (rst_n=0 at a clock edge): every registered output goes to 0, including out_valid. in_ready is 0 while rst_n=0.
- Format by opcode:
  - R: 0110011, 0111011.
  - I: 0010011, 0011011, 0000011, 1100111, 1110011.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Any other opcode: out_fmt=R, out_imm=0, out_illegal=1.
- Immediate generation:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All formats are sign-extended from the instruction's bit 31 to XLEN.
- Register usage:
  - uses_rs1 is set for R, I, S and B formats.
  - uses_rs2 is set for R, S and B formats.
- Hazard: hazard = in_valid & ex_mem_read & (ex_rd != 0) & ((uses_rs1 & ex_rd == rs1) | (uses_rs2 & ex_rd == rs2)).
- Bypass: if wb_we & (wb_rd != 0) & (wb_rd == rsN), the captured rsN data is wb_data, otherwise rf_dataN. Reads of x0 always capture 0, regardless of rf_data.
- Ready: in_ready = rst_n & (flush | ((!out_valid | out_ready) & !hazard)).
- Priority at each edge, highest first:
  1. reset;
  2. flush: out_valid <= 0 and the incoming instruction is discarded (in_ready=1 so upstream drains);
  3. accept (in_valid & in_ready): all out_* fields load, out_valid <= 1;
  4. drain (out_ready & !accept), which includes hazard cycles: out_valid <= 0, i.e. a bubble;
  5. stall (out_valid & !out_ready): all outputs hold unchanged.
- Latency: exactly 1 cycle from acceptance to out_valid. Throughput is 1 instruction/cycle when out_ready=1 and there is no hazard.
- out_* data fields are don't-care when out_valid=0, except after reset, when they are 0.
- A hazard never drops the instruction: in_ready=0 keeps it pending upstream until ex_mem_read deasserts.
- Simultaneous hazard and flush: flush wins.

Decomposition:
- Package rv_decode_pkg holds:
  - opcode localparams: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_IMM32, OP_REG, OP_REG32, OP_SYSTEM;
  - the fmt_t encoding (R..J).
- Sub-module rv_imm_gen (purely combinational: instr -> imm, fmt, illegal, uses_rs1, uses_rs2), parametrised by XLEN.

Test Plan:
- addi x1,x2,-5 (0xFFB10093), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=2, fmt=I, imm=0xFFFFFFFB.
- sw x5,8(x6) (0x00532423) -> imm=8, fmt=S. beq (0xFE208EE3) -> imm=0xFFFFFFFC, fmt=B. lui x3,0x12345 (0x123451B7) -> imm=0x12345000. jal x0,-8 (0xFF9FF06F) -> imm=0xFFFFFFF8, fmt=J.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and all outputs stable for 3 cycles; the next instruction appears the cycle after out_ready rises.
- ex_mem_read=1, ex_rd=5, input add x7,x5,x6 -> in_ready=0, one bubble (out_valid=0); release ex_mem_read -> instruction accepted next edge. Same case with ex_rd=0 -> no stall.
- wb_we=1, wb_rd=2, wb_data=0xDEADBEEF, rf_data1=0, input rs1=2 -> out_rs1_data=0xDEADBEEF. Reading x0 with rf_data1=0x55 -> out_rs1_data=0.
- flush asserted while a bundle is stalled and a new one is incoming -> next cycle out_valid=0 and in_ready=1 during flush. rst_n=0 mid-stream -> all outputs 0 the next edge. opcode 0x7F -> out_illegal=1, imm=0. XLEN=64 run with addi -5 -> imm=0xFFFFFFFFFFFFFFFB.
